inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the instruction RAM's write port.
- Accepts a byte stream (typically from a UART receiver) framed as: 4-byte word count, N 4-byte instruction words, 4-byte XOR checksum.
- Assembles little-endian words and drives single-cycle writes to consecutive word addresses.
- Flags completion or error to the core-reset/boot control logic.

Parameters:
- w, 32, data/address width; matches the instruction RAM.
- BASE_ADDR, 0, byte address of the first word written; word aligned.
- MAX_WORDS, 2048, largest accepted word count.
- TIMEOUT, 1000000, idle cycles allowed between accepted bytes before abort.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured in IDLE, DONE and ERR only.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte; byte transfers when rx_valid&&rx_ready.
- is_write  output  1  instruction RAM write strobe, one cycle per word.
- im_addr  output  w  byte address for the write.
- im_inst  output  w  instruction word for the write.
- busy  output  1  high while a load is in progress.
- done  output  1  load completed and checksum matched; held.
- err  output  1  load aborted; held.
- words_loaded  output  w  count of words written in the current/last load.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE immediately.
  - All outputs are 0; accumulator, byte count, word count, length, checksum and idle counter are cleared.
  - A partial word is discarded and no write is issued.
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
- rx_ready: high only in LEN, DATA and CSUM.
- busy: high in LEN, DATA, WRITE and CSUM.
- Outputs are registered. im_addr and im_inst hold their last values while is_write is 0.
- Byte assembly:
  - The k-th accepted byte of a word (k = 0..3) lands in acc[8k+7:8k].
  - The byte counter wraps 3 -> 0 when the word completes.
- IDLE/DONE/ERR, on start:
  - Go to LEN.
  - Clear done, err, words_loaded, checksum and word count.
- LEN, on the 4th byte:
  - len = assembled word.
  - len > MAX_WORDS -> ERR.
  - len == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA, on the 4th byte: go to WRITE.
- WRITE (exactly one cycle):
  - is_write = 1.
  - im_addr = BASE_ADDR + 4*word_cnt.
  - im_inst = assembled word.
  - checksum ^= word; word_cnt and words_loaded increment.
  - Next state: CSUM if the new word_cnt == len, otherwise DATA.
  - No byte is accepted in this cycle.
- CSUM, on the 4th byte:
  - Equal to the running XOR -> DONE (done = 1).
  - Otherwise -> ERR (err = 1).
- Timeout:
  - In LEN/DATA/CSUM, the idle counter increments each cycle with no accepted byte and clears on every accept.
  - It also clears on entry to LEN.
  - When it reaches TIMEOUT -> ERR; the partial word is discarded.
- done and err are mutually exclusive and hold until the next start or rst.
- start is ignored while busy.
- rx_valid outside LEN/DATA/CSUM is ignored (rx_ready = 0).
- Simultaneous 4th byte and timeout threshold in the same cycle: the byte wins and the counter clears.
- Address arithmetic is modulo 2^w. It cannot overflow for legal BASE_ADDR + 4*MAX_WORDS.

Test Plan:
- Two-word load with BASE_ADDR=0:
  - Stimulus: start, then bytes 02 00 00 00 | 13 00 00 00 | 97 01 00 00 | 84 01 00 00.
  - Required: is_write pulses with (0x0, 0x00000013) and (0x4, 0x00000197); rx_ready low in each WRITE cycle; done=1, err=0, words_loaded=2, busy=0.
- Bad checksum:
  - Stimulus: same stream with the checksum bytes changed to 85 01 00 00.
  - Required: both writes occur; err=1, done=0.
- Oversized length with MAX_WORDS=2048:
  - Stimulus: bytes 01 08 00 00 (len 0x801).
  - Required: err=1 in the cycle after the 4th byte; is_write never asserted.
- Timeout with TIMEOUT=16:
  - Stimulus: length 01 00 00 00, then two data bytes, then rx_valid held low.
  - Required: err=1 exactly 16 cycles after the last accepted byte; no write.
- Reset mid-word:
  - Stimulus: assert rst asynchronously after 2 data bytes.
  - Required: all outputs 0 without waiting for a clock edge.
  - Follow-up: a fresh start and the 1-word stream 01 00 00 00 | 13 00 00 00 | 13 00 00 00 writes (0x0, 0x00000013) and sets done=1.
- Zero-length load, then restart:
  - Stimulus: 00 00 00 00 | 00 00 00 00.
  - Required: done=1 with no writes.
  - Follow-up: a start pulse while busy in the next load is ignored; start from DONE clears done and begins a new load.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-stream input, instruction-RAM write port and boot status of inst_loader.
// The master modport is the loader; the slave modport is the environment around it.
interface inst_loader_if #(
  parameter int unsigned w = 32
);
  logic         start;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         is_write;
  logic [w-1:0] im_addr;
  logic [w-1:0] im_inst;
  logic         busy;
  logic         done;
  logic         err;
  logic [w-1:0] words_loaded;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, is_write, im_addr, im_inst, busy, done, err, words_loaded
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, is_write, im_addr, im_inst, busy, done, err, words_loaded
  );
endinterface

// File: rtl/inst_loader.sv
// Boot loader: parses a length / words / XOR-checksum byte stream (little-endian)
// and writes the words to consecutive instruction RAM addresses.
module inst_loader #(
  parameter int unsigned w         = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 2048,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input logic          clk,
  input logic          rst,
  inst_loader_if.master bus
);

  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t       state_q, state_d;
  logic [23:0]  acc_q, acc_d;
  logic [1:0]   bcnt_q, bcnt_d;
  logic [w-1:0] wcnt_q, wcnt_d;
  logic [w-1:0] len_q, len_d;
  logic [31:0]  csum_q, csum_d;
  logic [IW-1:0] idle_q, idle_d;
  logic         is_write_q, is_write_d;
  logic [w-1:0] addr_q, addr_d;
  logic [w-1:0] inst_q, inst_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [w-1:0] wl_q, wl_d;

  logic         rx_ready;
  logic         accept;
  logic         last_byte;
  logic         timed_out;
  logic [31:0]  word;

  assign rx_ready  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept    = rx_ready && bus.rx_valid;
  assign last_byte = accept && (bcnt_q == 2'd3);
  // The fourth byte is used straight off the bus, so only three bytes are buffered.
  assign word      = {bus.rx_data, acc_q};
  assign timed_out = rx_ready && !accept && (idle_q == IW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    len_d      = len_q;
    csum_d     = csum_q;
    idle_d     = idle_q;
    is_write_d = 1'b0;
    addr_d     = addr_q;
    inst_d     = inst_q;
    done_d     = done_q;
    err_d      = err_q;
    wl_d       = wl_q;

    if (accept) begin
      bcnt_d = bcnt_q + 2'd1;
      idle_d = '0;
      case (bcnt_q)
        2'd0:    acc_d[7:0]   = bus.rx_data;
        2'd1:    acc_d[15:8]  = bus.rx_data;
        2'd2:    acc_d[23:16] = bus.rx_data;
        default: acc_d        = '0;
      endcase
    end else if (rx_ready) begin
      idle_d = idle_q + IW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wl_d    = '0;
          csum_d  = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
          acc_d   = '0;
          idle_d  = '0;
        end
      end
      S_LEN: begin
        if (last_byte) begin
          len_d = w'(word);
          if (word > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (word == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          state_d    = S_WRITE;
          is_write_d = 1'b1;
          addr_d     = w'(BASE_ADDR) + (wcnt_q << 2);
          inst_d     = w'(word);
        end
      end
      S_WRITE: begin
        csum_d  = csum_q ^ 32'(inst_q);
        wcnt_d  = wcnt_q + w'(1);
        wl_d    = wl_q + w'(1);
        state_d = (wcnt_q + w'(1) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (last_byte) begin
          if (word == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte completing a word takes priority over the timeout in the same cycle.
    if (timed_out) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      bcnt_d  = '0;
      acc_d   = '0;
      idle_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      idle_q     <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      inst_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wl_q       <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      idle_q     <= idle_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wl_q       <= wl_d;
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.busy         = rx_ready || (state_q == S_WRITE);
  assign bus.is_write     = is_write_q;
  assign bus.im_addr      = addr_q;
  assign bus.im_inst      = inst_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.words_loaded = wl_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed test of inst_loader: normal load, bad checksum, oversize length,
// timeout, asynchronous reset mid-word, zero-length load and restart.
module tb_inst_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_loader_if #(.w(32)) bus ();

  inst_loader #(
    .w(32),
    .BASE_ADDR(0),
    .MAX_WORDS(2048),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int rdy_in_write = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_inst [16];

  always @(negedge clk) begin
    if (bus.is_write) begin
      wr_addr[wr_total % 16] <= bus.im_addr;
      wr_inst[wr_total % 16] <= bus.im_inst;
      wr_total <= wr_total + 1;
      if (bus.rx_ready) rdy_in_write <= rdy_in_write + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", bus.rx_ready === 1'b1, bus.rx_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] wd);
    send_byte(wd[7:0]);
    send_byte(wd[15:8]);
    send_byte(wd[23:16]);
    send_byte(wd[31:24]);
  endtask

  int base;

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #3;
    chk("reset_busy", bus.busy === 1'b0, bus.busy, 1'b0);
    chk("reset_done", bus.done === 1'b0, bus.done, 1'b0);
    chk("reset_err", bus.err === 1'b0, bus.err, 1'b0);
    chk("reset_rx_ready", bus.rx_ready === 1'b0, bus.rx_ready, 1'b0);
    chk("reset_words", bus.words_loaded === 32'h0, bus.words_loaded, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    base = wr_total;
    pulse_start();
    chk("t1_busy_after_start", bus.busy === 1'b1, bus.busy, 1'b1);
    send_word(32'h2);
    send_word(32'h13);
    send_word(32'h197);
    send_word(32'h184);
    chk("t1_done", bus.done === 1'b1, bus.done, 1'b1);
    chk("t1_err", bus.err === 1'b0, bus.err, 1'b0);
    chk("t1_busy", bus.busy === 1'b0, bus.busy, 1'b0);
    chk("t1_words", bus.words_loaded === 32'h2, bus.words_loaded, 32'h2);
    chk("t1_nwrites", (wr_total - base) === 2, wr_total - base, 2);
    chk("t1_addr0", wr_addr[base % 16] === 32'h0, wr_addr[base % 16], 32'h0);
    chk("t1_inst0", wr_inst[base % 16] === 32'h13, wr_inst[base % 16], 32'h13);
    chk("t1_addr1", wr_addr[(base + 1) % 16] === 32'h4, wr_addr[(base + 1) % 16], 32'h4);
    chk("t1_inst1", wr_inst[(base + 1) % 16] === 32'h197, wr_inst[(base + 1) % 16], 32'h197);
    chk("t1_rx_ready_in_write", rdy_in_write === 0, rdy_in_write, 0);

    base = wr_total;
    pulse_start();
    chk("t2_done_cleared", bus.done === 1'b0, bus.done, 1'b0);
    send_word(32'h2);
    send_word(32'h13);
    send_word(32'h197);
    send_word(32'h185);
    chk("t2_err", bus.err === 1'b1, bus.err, 1'b1);
    chk("t2_done", bus.done === 1'b0, bus.done, 1'b0);
    chk("t2_nwrites", (wr_total - base) === 2, wr_total - base, 2);

    base = wr_total;
    pulse_start();
    chk("t3_err_cleared", bus.err === 1'b0, bus.err, 1'b0);
    send_word(32'h801);
    chk("t3_err", bus.err === 1'b1, bus.err, 1'b1);
    chk("t3_busy", bus.busy === 1'b0, bus.busy, 1'b0);
    chk("t3_nwrites", (wr_total - base) === 0, wr_total - base, 0);

    base = wr_total;
    pulse_start();
    send_word(32'h1);
    send_byte(8'h13);
    send_byte(8'h00);
    for (int i = 0; i < 15; i++) @(negedge clk);
    chk("t4_err_before_16", bus.err === 1'b0, bus.err, 1'b0);
    chk("t4_busy_before_16", bus.busy === 1'b1, bus.busy, 1'b1);
    @(negedge clk);
    chk("t4_err_at_16", bus.err === 1'b1, bus.err, 1'b1);
    chk("t4_nwrites", (wr_total - base) === 0, wr_total - base, 0);

    pulse_start();
    send_word(32'h1);
    send_byte(8'h13);
    send_byte(8'h00);
    chk("t5_busy_pre_rst", bus.busy === 1'b1, bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy", bus.busy === 1'b0, bus.busy, 1'b0);
    chk("t5_rx_ready", bus.rx_ready === 1'b0, bus.rx_ready, 1'b0);
    chk("t5_err", bus.err === 1'b0, bus.err, 1'b0);
    chk("t5_done", bus.done === 1'b0, bus.done, 1'b0);
    chk("t5_is_write", bus.is_write === 1'b0, bus.is_write, 1'b0);
    chk("t5_im_addr", bus.im_addr === 32'h0, bus.im_addr, 32'h0);
    chk("t5_im_inst", bus.im_inst === 32'h0, bus.im_inst, 32'h0);
    chk("t5_words", bus.words_loaded === 32'h0, bus.words_loaded, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    base = wr_total;
    pulse_start();
    send_word(32'h1);
    send_word(32'h13);
    send_word(32'h13);
    chk("t5b_done", bus.done === 1'b1, bus.done, 1'b1);
    chk("t5b_nwrites", (wr_total - base) === 1, wr_total - base, 1);
    chk("t5b_addr", wr_addr[base % 16] === 32'h0, wr_addr[base % 16], 32'h0);
    chk("t5b_inst", wr_inst[base % 16] === 32'h13, wr_inst[base % 16], 32'h13);

    base = wr_total;
    pulse_start();
    send_word(32'h0);
    send_word(32'h0);
    chk("t6_done", bus.done === 1'b1, bus.done, 1'b1);
    chk("t6_words", bus.words_loaded === 32'h0, bus.words_loaded, 32'h0);
    chk("t6_nwrites", (wr_total - base) === 0, wr_total - base, 0);

    base = wr_total;
    pulse_start();
    chk("t7_done_cleared", bus.done === 1'b0, bus.done, 1'b0);
    chk("t7_busy", bus.busy === 1'b1, bus.busy, 1'b1);
    send_byte(8'h01);
    pulse_start();
    chk("t7_busy_after_ignored_start", bus.busy === 1'b1, bus.busy, 1'b1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h13);
    send_word(32'h13);
    chk("t7_done", bus.done === 1'b1, bus.done, 1'b1);
    chk("t7_err", bus.err === 1'b0, bus.err, 1'b0);
    chk("t7_words", bus.words_loaded === 32'h1, bus.words_loaded, 32'h1);
    chk("t7_nwrites", (wr_total - base) === 1, wr_total - base, 1);
    chk("t7_inst", wr_inst[base % 16] === 32'h13, wr_inst[base % 16], 32'h13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
